// File: rtl/pc_gen.sv
// Fetch program-counter generator: reset hold, sequential step, redirect with
// alignment, trap entry with saved EPC, and trap return.
module pc_gen #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
    parameter int unsigned      STEP         = 4,
    parameter int unsigned      ALIGN_BITS   = 2,
    parameter int unsigned      HOLD_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_in,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             trap_valid,
    input  logic [WIDTH-1:0] trap_pc,
    input  logic             mret_valid,
    output logic [WIDTH-1:0] PC,
    output logic             pc_valid,
    output logic [WIDTH-1:0] epc,
    output logic             misalign
);

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);

    localparam logic [0:0] ST_HOLD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q,    state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0] pc_q,       pc_d;
    logic [WIDTH-1:0] epc_q,      epc_d;
    logic             misalign_q, misalign_d;

    always_comb begin
        // NOTE: every _d signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = misalign_q;

        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            ST_RUN: begin
                misalign_d = 1'b0;
                // Priority: trap > mret > redirect > stall > sequential step.
                if (trap_valid) begin
                    pc_d  = TRAP_VECTOR;
                    epc_d = trap_pc;
                end else if (mret_valid) begin
                    pc_d = epc_q;
                end else if (redirect_valid) begin
                    pc_d       = redirect_pc & ~ALIGN_MASK;
                    misalign_d = |(redirect_pc & ALIGN_MASK);
                end else if (!stall_in) begin
                    pc_d = pc_q + STEP_W;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= CNT_W'(HOLD_CYCLES - 1);
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            misalign_q <= misalign_d;
        end
    end

    assign PC       = pc_q;
    assign pc_valid = (state_q == ST_RUN);
    assign epc      = epc_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit instance with a 3-edge reset hold and an
// 8-bit instance for wrap-around; directed vectors with hand-computed results.
module tb_pc_gen;

    typedef struct {
        logic        sel_b;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] epc;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_b_n = 1'b0;
    logic        stall_in = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_pc = '0;
    logic        mret_valid = 1'b0;

    logic [31:0] pc_a, epc_a;
    logic        valid_a, mis_a;
    logic [7:0]  pc_b, epc_b;
    logic        valid_b, mis_b;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_gen #(.HOLD_CYCLES(3)) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .mret_valid     (mret_valid),
        .PC             (pc_a),
        .pc_valid       (valid_a),
        .epc            (epc_a),
        .misalign       (mis_a)
    );

    pc_gen #(
        .WIDTH        (8),
        .RESET_VECTOR (8'h00),
        .TRAP_VECTOR  (8'h40),
        .STEP         (4),
        .ALIGN_BITS   (2),
        .HOLD_CYCLES  (1)
    ) dut_b (
        .clk            (clk),
        .rst_n          (rst_b_n),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc[7:0]),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc[7:0]),
        .mret_valid     (mret_valid),
        .PC             (pc_b),
        .pc_valid       (valid_b),
        .epc            (epc_b),
        .misalign       (mis_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Called at negedge+1: apply inputs, queue the state expected after the next posedge.
    task automatic cyc(input logic sel_b, input logic st, input logic rv, input logic [31:0] rpc,
                       input logic tv, input logic [31:0] tpc, input logic mv,
                       input logic [31:0] e_pc, input logic e_v, input logic [31:0] e_epc,
                       input logic e_mis);
        exp_t e;
        stall_in       = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        trap_valid     = tv;
        trap_pc        = tpc;
        mret_valid     = mv;
        e.sel_b = sel_b;
        e.pc    = e_pc;
        e.valid = e_v;
        e.epc   = e_epc;
        e.mis   = e_mis;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Monitor: compares the DUT state one half-cycle after each edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (!e.sel_b) begin
                check("a_pc",       pc_a,              e.pc);
                check("a_pc_valid", {31'b0, valid_a},  {31'b0, e.valid});
                check("a_epc",      epc_a,             e.epc);
                check("a_misalign", {31'b0, mis_a},    {31'b0, e.mis});
            end else begin
                check("b_pc",       {24'b0, pc_b},     e.pc);
                check("b_pc_valid", {31'b0, valid_b},  {31'b0, e.valid});
                check("b_epc",      {24'b0, epc_b},    e.epc);
                check("b_misalign", {31'b0, mis_b},    {31'b0, e.mis});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        check("rst_a_pc",    pc_a,             32'h0);
        check("rst_a_valid", {31'b0, valid_a}, 32'h0);
        check("rst_a_epc",   epc_a,            32'h0);
        check("rst_b_valid", {31'b0, valid_b}, 32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Hold: requests ignored for three edges, pc_valid rises after the third.
        cyc(0, 0, 0, 32'h0,   1, 32'h3C, 0, 32'h0, 0, 32'h0, 0);
        cyc(0, 0, 1, 32'h80,  0, 32'h0,  0, 32'h0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0, 1, 32'h0, 0);
        for (int i = 1; i <= 8; i++)
            cyc(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'(i * 4), 1, 32'h0, 0);

        // Stall, then redirect overriding a stall.
        cyc(0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h20,  1, 32'h0, 0);
        cyc(0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h20,  1, 32'h0, 0);
        cyc(0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h24,  1, 32'h0, 0);
        cyc(0, 1, 1, 32'h80,  0, 32'h0,  0, 32'h80,  1, 32'h0, 0);

        // Misaligned redirect: one-cycle pulse.
        cyc(0, 0, 1, 32'h103, 0, 32'h0,  0, 32'h100, 1, 32'h0, 1);
        cyc(0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h104, 1, 32'h0, 0);

        // Trap entry and return.
        cyc(0, 0, 1, 32'h40,  0, 32'h0,  0, 32'h40,  1, 32'h0,  0);
        cyc(0, 0, 0, 32'h0,   1, 32'h3C, 0, 32'h100, 1, 32'h3C, 0);
        cyc(0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h104, 1, 32'h3C, 0);
        cyc(0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h3C,  1, 32'h3C, 0);

        // Priority: trap beats mret/redirect/stall; mret beats a misaligned redirect.
        cyc(0, 1, 1, 32'h200, 1, 32'h50, 1, 32'h100, 1, 32'h50, 0);
        cyc(0, 1, 1, 32'h303, 0, 32'h0,  1, 32'h50,  1, 32'h50, 0);
        cyc(0, 0, 0, 32'h0,   1, 32'h3C, 0, 32'h100, 1, 32'h3C, 0);
        cyc(0, 0, 1, 32'h58,  0, 32'h0,  0, 32'h58,  1, 32'h3C, 0);

        // Asynchronous reset between edges at PC=0x58, epc=0x3C.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc",       pc_a,             32'h0);
        check("async_epc",      epc_a,            32'h0);
        check("async_pc_valid", {31'b0, valid_a}, 32'h0);
        check("async_misalign", {31'b0, mis_a},   32'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h4, 1, 32'h0, 0);

        // 8-bit instance: single-edge hold, misaligned redirect to the top, wrap.
        rst_b_n = 1'b1;
        cyc(1, 0, 0, 32'h0,  0, 32'h0,  0, 32'h00, 1, 32'h0,  0);
        cyc(1, 0, 1, 32'hFE, 0, 32'h0,  0, 32'hFC, 1, 32'h0,  1);
        cyc(1, 0, 0, 32'h0,  0, 32'h0,  0, 32'h00, 1, 32'h0,  0);
        cyc(1, 0, 0, 32'h0,  0, 32'h0,  0, 32'h04, 1, 32'h0,  0);
        cyc(1, 0, 0, 32'h0,  1, 32'h3C, 0, 32'h40, 1, 32'h3C, 0);
        cyc(1, 0, 0, 32'h0,  0, 32'h0,  1, 32'h3C, 1, 32'h3C, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
